btn_mode_ctrl: RTL and testbench
================================

BTN_MODE_CTRL -- requirements
Module: btn_mode_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz), meaning the number of consecutive stable cycles needed to accept a button level.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btn_raw, input, 1 bit: the asynchronous push-button, active high, may bounce.
REQ-006 The block SHALL have port mode, output, 2 bits: current blink mode (00 OFF, 01 SLOW, 10 MED, 11 FAST).
REQ-007 The block SHALL have port blink_en, output, 1 bit: high whenever mode != OFF.
REQ-008 The block SHALL have port tick, output, 1 bit: single-cycle toggle strobe for the downstream LED blinker.
REQ-009 The block SHALL have port press, output, 1 bit: single-cycle pulse marking an accepted button press.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounce: a counter SHALL increment each cycle the synchronized level differs from the debounced level, and SHALL clear in any cycle they are equal.
REQ-012 When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL flip on that edge and the counter SHALL clear.
REQ-013 Timing: with btn_raw first sampled stable-high at edge N, the debounced level SHALL flip at edge N+1+DEBOUNCE_CYCLES.
REQ-014 press SHALL be high for exactly the one cycle following each 0->1 debounced flip; a 1->0 flip SHALL NOT produce press.
REQ-015 Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no flip and no press.
REQ-016 Mode FSM: the sequence SHALL be OFF->SLOW->MED->FAST->OFF, advancing once per press, with mode updating at the edge that ends the press cycle.
REQ-017 Half-period in cycles SHALL be CLK_HZ/2 for SLOW, CLK_HZ/4 for MED, and CLK_HZ/8 for FAST, using integer division; a half-period of 0 SHALL be treated as 1.
REQ-018 Tick counter: it SHALL clear on every mode change and be held at 0 in OFF; otherwise it SHALL count 0..HALF-1, pulse tick when at HALF-1, and wrap to 0.
REQ-019 First tick after entering a non-OFF mode SHALL occur HALF cycles after the mode update edge; subsequent ticks SHALL occur every HALF cycles.
REQ-020 tick SHALL never assert while mode is OFF, nor in the cycle mode changes.
REQ-021 Counter widths SHALL be $clog2 of their maximum count, with no overflow at the default parameters.

Reset
REQ-022 While rst is high at an edge: synchronizer flops, debounced level, and all counters SHALL become 0; mode SHALL become OFF; tick, press and blink_en SHALL become 0.
REQ-023 Reset asserted mid-count or mid-debounce SHALL abandon the operation with no residual tick or press after release.
REQ-024 After rst deasserts with btn_raw held high, the block SHALL register one press, following the REQ-013 timing.

Structure
REQ-025 Shared package led_ctrl_pkg SHALL hold the mode enum (OFF/SLOW/MED/FAST) and a function returning the half-period for (CLK_HZ, mode).
REQ-026 Synchronizer plus debounce plus edge detection SHALL form sub-module btn_debounce (ports clk, rst, btn_raw, level, rise); btn_mode_ctrl SHALL contain the FSM and tick divider.
REQ-027 tick SHALL be registered with no combinational path from btn_raw to any output.

Verification (CLK_HZ=80, DEBOUNCE_CYCLES=4, so HALF = 40/20/10)
REQ-028 Reset check: rst high 2 cycles, btn_raw=0, run 200 cycles -> mode=00, blink_en=0, zero ticks, zero presses.
REQ-029 Bounce check: btn_raw toggles every 2 cycles for 20 cycles, then held high -> exactly one press, mode=01, first tick 40 cycles after the mode edge.
REQ-030 Mode-cycle check: 4 clean presses (high 10 / low 10, spaced 150 cycles) -> mode 01,10,11,00 with tick spacing 40,20,10 then none, and blink_en falls at 00.
REQ-031 Glitch check: in mode 10, btn_raw pulsed high 3 cycles -> no press, and the mode and tick cadence are unchanged.
REQ-032 Mid-op reset check: in FAST, 5 cycles after a tick, rst for 1 cycle -> mode=00, tick=0 from the next edge, and no tick for 100 cycles.
REQ-033 Hold check: btn_raw held high 500 cycles -> exactly one press, and release produces none.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the button-driven LED blink controller.
// Holds the blink mode encoding and the per-mode tick half-period.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_MED  = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  function automatic int unsigned half_period(
    input int unsigned clk_hz,
    input mode_e       m
  );
    int unsigned h;
    case (m)
      MODE_SLOW: h = clk_hz / 2;
      MODE_MED:  h = clk_hz / 4;
      MODE_FAST: h = clk_hz / 8;
      default:   h = 1;
    endcase
    // very slow clocks can divide down to zero
    if (h == 0) h = 1;
    return h;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer, debouncer and rising-edge detector.
// level follows btn_raw only after DEBOUNCE_CYCLES stable cycles.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/btn_mode_ctrl.sv
// Blink-mode controller: each debounced press steps OFF/SLOW/MED/FAST,
// and a per-mode divider emits a registered tick every half-period.
module btn_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic [1:0] mode,
  output logic       blink_en,
  output logic       tick,
  output logic       press
);

  localparam int HMAX = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
  localparam int TW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  logic          level;
  logic          rise;
  mode_e         mode_q, mode_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] half_m1;
  logic          tick_q, tick_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .level  (level),
    .rise   (rise)
  );

  // rise is only ever set together with an accepted high level
  assign press = rise & level;

  always_comb begin
    mode_d = mode_q;
    if (press) begin
      unique case (mode_q)
        MODE_OFF:  mode_d = MODE_SLOW;
        MODE_SLOW: mode_d = MODE_MED;
        MODE_MED:  mode_d = MODE_FAST;
        MODE_FAST: mode_d = MODE_OFF;
      endcase
    end
  end

  always_comb begin
    half_m1 = TW'(half_period(CLK_HZ, mode_q) - 1);
    cnt_d   = '0;
    tick_d  = 1'b0;
    if (press || mode_q == MODE_OFF) begin
      cnt_d = '0;
    end else if (cnt_q == half_m1) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign mode     = mode_q;
  assign blink_en = (mode_q != MODE_OFF);
  assign tick     = tick_q;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Scoreboard bench for btn_mode_ctrl at CLK_HZ=80, DEBOUNCE_CYCLES=4.
// Driver queues expected press/tick cycles; a monitor pops and compares.
module tb_btn_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic [1:0] mode;
  logic       blink_en;
  logic       tick;
  logic       press;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int exp_press[$];
  int exp_tick[$];

  btn_mode_ctrl #(
    .CLK_HZ         (80),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .mode    (mode),
    .blink_en(blink_en),
    .tick    (tick),
    .press   (press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  function automatic int half_of(input logic [1:0] m);
    case (m)
      2'd1:    return 40;
      2'd2:    return 20;
      2'd3:    return 10;
      default: return 0;
    endcase
  endfunction

  // monitor: every press/tick must match the head of its queue
  always @(negedge clk) begin
    if (press === 1'b1) begin
      if (exp_press.size() == 0) chk("press_unexpected", cyc, -1);
      else chk("press_cycle", cyc, exp_press.pop_front());
    end
    if (tick === 1'b1) begin
      chk("tick_mode_on", int'(mode != 2'd0), 1);
      if (exp_tick.size() == 0) chk("tick_unexpected", cyc, -1);
      else chk("tick_cycle", cyc, exp_tick.pop_front());
    end
  end

  // one press starting now; len cycles until the next drive
  task automatic seg(input int hi, input int len,
                     input logic [1:0] m, input bit gl);
    int c;
    int h;
    c = cyc;
    btn_raw = 1'b1;
    exp_press.push_back(c + 6);
    h = half_of(m);
    if (h > 0)
      for (int k = 1; h * k < len; k++)
        exp_tick.push_back(c + 7 + h * k);
    repeat (8) @(negedge clk);
    chk("mode_after_press", mode, m);
    chk("blink_en", blink_en, int'(m != 2'd0));
    repeat (hi - 8) @(negedge clk);
    btn_raw = 1'b0;
    if (gl) begin
      repeat (40 - hi) @(negedge clk);
      btn_raw = 1'b1;
      repeat (3) @(negedge clk);
      btn_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("mode_after_glitch", mode, m);
      repeat (len - 63) @(negedge clk);
    end else begin
      repeat (len - hi) @(negedge clk);
    end
  endtask

  task automatic fast_reset();
    int c;
    c = cyc;
    btn_raw = 1'b1;
    exp_press.push_back(c + 6);
    exp_tick.push_back(c + 17);
    exp_tick.push_back(c + 27);
    repeat (8) @(negedge clk);
    chk("mode_fast", mode, 3);
    repeat (2) @(negedge clk);
    btn_raw = 1'b0;
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mode", mode, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_blink", blink_en, 0);
    repeat (100) @(negedge clk);
    chk("midrst_mode_late", mode, 0);
  endtask

  task automatic reset_held_high();
    int c;
    c = cyc;
    rst = 1'b1;
    btn_raw = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_high_mode", mode, 0);
    chk("rst_high_blink", blink_en, 0);
    exp_press.push_back(c + 8);
    for (int k = 1; 9 + 40 * k <= 140; k++)
      exp_tick.push_back(c + 9 + 40 * k);
    repeat (10) @(negedge clk);
    chk("rst_high_press_mode", mode, 1);
    repeat (88) @(negedge clk);
    btn_raw = 1'b0;
    repeat (50) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mode", mode, 0);
    chk("rst_blink", blink_en, 0);
    chk("rst_tick", tick, 0);
    chk("rst_press", press, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("idle_mode", mode, 0);
    chk("idle_blink", blink_en, 0);

    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    seg(10, 120, 2'd1, 1'b0);
    seg(10, 120, 2'd2, 1'b1);
    fast_reset();

    seg(10, 150, 2'd1, 1'b0);
    seg(10, 150, 2'd2, 1'b0);
    seg(10, 150, 2'd3, 1'b0);
    seg(10, 150, 2'd0, 1'b0);

    seg(500, 600, 2'd1, 1'b0);
    reset_held_high();

    @(negedge clk);
    chk("press_queue_empty", exp_press.size(), 0);
    chk("tick_queue_empty", exp_tick.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
